// File: rtl/count_match_irq.sv
// count_match_irq: three-channel compare/interrupt stage fed by the free-running
// counter. One-shot or periodic compare channels, sticky W1C pending bits,
// a mask register and per-channel saturating hit counters.
// Configured over a single-cycle-ack Wishbone-style register port.
module count_match_irq #(
  parameter int BITS = 32,
  parameter int NCH  = 3,
  parameter int HITW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic            we,
  input  logic [3:0]      sel,
  input  logic [2:0]      adr,
  input  logic [31:0]     wdata,
  output logic            ready,
  output logic [31:0]     rdata,
  input  logic [BITS-1:0] count,
  output logic [NCH-1:0]  irq
);

  localparam logic [2:0] ADR_CTRL   = 3'd0;
  localparam logic [2:0] ADR_STATUS = 3'd1;
  localparam logic [2:0] ADR_MASK   = 3'd2;
  localparam logic [2:0] ADR_HITS   = 3'd3;
  localparam logic [2:0] ADR_CMP0   = 3'd4;

  logic [NCH-1:0]  en, rearm, pend, mask, match_q;
  logic [NCH-1:0]  hit, rise, cmp_wr;
  logic [HITW-1:0] hits [NCH];
  logic [BITS-1:0] cmp  [NCH];

  logic        access, wr, rd;
  logic        ctrl_wr, status_wr, mask_wr;
  logic [31:0] read_word;

  // A request is accepted only while no ack is outstanding, so back-to-back
  // valid produces an ack every other cycle.
  assign access    = valid & ~ready;
  assign wr        = access & we;
  assign rd        = access & ~we;
  assign ctrl_wr   = wr & (adr == ADR_CTRL)   & sel[0];
  assign status_wr = wr & (adr == ADR_STATUS) & sel[0];
  assign mask_wr   = wr & (adr == ADR_MASK)   & sel[0];

  // Per-channel equality and rising-edge detect; a stalled counter fires once.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hit[i]    = en[i] & (count == cmp[i]);
      rise[i]   = hit[i] & ~match_q[i];
      cmp_wr[i] = wr & (adr == 3'(ADR_CMP0 + i)) & (|sel);
    end
  end

  // Read mux over the current register contents.
  always_comb begin
    // NOTE: every path assigns read_word first, so no latch can be inferred.
    read_word = '0;
    case (adr)
      ADR_CTRL: begin
        read_word[NCH-1:0] = en;
        read_word[4 +: NCH] = rearm;
      end
      ADR_STATUS: read_word[NCH-1:0] = pend;
      ADR_MASK:   read_word[NCH-1:0] = mask;
      ADR_HITS: begin
        for (int i = 0; i < NCH; i++) read_word[i*HITW +: HITW] = hits[i];
      end
      3'd4, 3'd5, 3'd6: read_word = 32'(cmp[adr - ADR_CMP0]);
      default: read_word = '0;
    endcase
  end

  // Bus handshake: one-cycle ack, read data captured on the accepting edge.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= access;
      if (rd) rdata <= read_word;
    end
  end

  // Control, pending and mask registers. A pending set beats a same-cycle
  // W1C, and a CTRL write beats a same-cycle one-shot auto-disable.
  always_ff @(posedge clk) begin
    if (reset) begin
      en    <= '0;
      rearm <= '0;
      pend  <= '0;
      mask  <= '0;
    end else begin
      if (ctrl_wr) begin
        en    <= wdata[NCH-1:0];
        rearm <= wdata[4 +: NCH];
      end else begin
        en    <= en & ~(rise & ~rearm);
      end
      pend <= (pend & ~(status_wr ? wdata[NCH-1:0] : '0)) | rise;
      if (mask_wr) mask <= wdata[NCH-1:0];
    end
  end

  // Compare values, hit counters and match history. A compare write clears
  // the channel's history so a new value equal to count fires next cycle.
  always_ff @(posedge clk) begin
    // NOTE: the compare and hit arrays have defined reset values, so they are
    // reset explicitly element by element rather than left to power-up.
    if (reset) begin
      match_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cmp[i]  <= '1;
        hits[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cmp_wr[i]) begin
          for (int b = 0; b < BITS/8; b++) begin
            if (sel[b]) cmp[i][8*b +: 8] <= wdata[8*b +: 8];
          end
          hits[i]    <= '0;
          match_q[i] <= 1'b0;
        end else begin
          match_q[i] <= hit[i];
          if (rise[i] && (hits[i] != '1)) hits[i] <= hits[i] + 1'b1;
        end
      end
    end
  end

  // Level interrupts straight from registers.
  assign irq = pend & mask;

endmodule

// File: tb/tb_count_match_irq.sv
// Self-checking bench for count_match_irq: directed scenarios plus a randomized
// phase, all compared against a behavioural register-map model.
module tb_count_match_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, we;
  logic [3:0]  sel;
  logic [2:0]  adr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic [31:0] count;
  logic [2:0]  irq;

  int n_checks = 0;
  int n_errors = 0;
  bit cnt_run  = 1'b0;

  count_match_irq dut (
    .clk(clk), .reset(reset), .valid(valid), .we(we), .sel(sel), .adr(adr),
    .wdata(wdata), .ready(ready), .rdata(rdata), .count(count), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit [2:0]  m_en, m_rearm, m_pend, m_mask, m_prev;
  int        m_hits [3];
  bit [31:0] m_cmp  [3];
  bit        m_ready;
  bit [31:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [31:0] m_word(input int a);
    case (a)
      0: return {25'h0, m_rearm, 1'b0, m_en};
      1: return {29'h0, m_pend};
      2: return {29'h0, m_mask};
      3: return {8'h0, 8'(m_hits[2]), 8'(m_hits[1]), 8'(m_hits[0])};
      4, 5, 6: return m_cmp[a-4];
      default: return 32'h0;
    endcase
  endfunction

  // One clock of the register map, evaluated from the rules on pre-edge values.
  task automatic model_step();
    bit acc, wr, rd;
    bit [2:0] hitv, rise, w1c;
    if (reset) begin
      m_en = 0; m_rearm = 0; m_pend = 0; m_mask = 0; m_prev = 0;
      m_ready = 0; m_rdata = 0;
      for (int i = 0; i < 3; i++) begin m_hits[i] = 0; m_cmp[i] = 32'hFFFF_FFFF; end
      return;
    end
    acc = valid && !m_ready;
    wr  = acc && we;
    rd  = acc && !we;
    for (int i = 0; i < 3; i++) begin
      hitv[i] = m_en[i] && (count == m_cmp[i]);
      rise[i] = hitv[i] && !m_prev[i];
    end
    if (rd) m_rdata = m_word(int'(adr));
    m_ready = acc;
    w1c = (wr && adr == 1 && sel[0]) ? wdata[2:0] : 3'b0;
    m_pend = (m_pend & ~w1c) | rise;
    if (wr && adr == 0 && sel[0]) begin
      m_en = wdata[2:0]; m_rearm = wdata[6:4];
    end else begin
      m_en = m_en & ~(rise & ~m_rearm);
    end
    if (wr && adr == 2 && sel[0]) m_mask = wdata[2:0];
    for (int i = 0; i < 3; i++) begin
      if (wr && int'(adr) == 4 + i && sel != 0) begin
        for (int b = 0; b < 4; b++) if (sel[b]) m_cmp[i][8*b +: 8] = wdata[8*b +: 8];
        m_hits[i] = 0;
        m_prev[i] = 0;
      end else begin
        if (rise[i] && m_hits[i] < 255) m_hits[i]++;
        m_prev[i] = hitv[i];
      end
    end
  endtask

  // Advance one clock, then compare every output against the model.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (cnt_run) count = count + 1;
    check("ready", {31'h0, ready}, {31'h0, m_ready});
    check("rdata", rdata, m_rdata);
    check("irq", {29'h0, irq}, {29'h0, m_pend & m_mask});
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
    valid = 1; we = 1; adr = a; sel = s; wdata = d;
    tick();
    valid = 0; we = 0;
    tick();
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    valid = 1; we = 0; adr = a; sel = 4'hF;
    tick();
    valid = 0;
    d = rdata;
    tick();
  endtask

  logic [31:0] rd_v;
  bit   [31:0] exp_rst [8];

  initial begin
    exp_rst = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    reset = 1; valid = 0; we = 0; sel = 0; adr = 0; wdata = 0; count = 0;
    tick(); tick();
    reset = 0;

    // Reset state of every word.
    for (int a = 0; a < 8; a++) begin
      wb_read(3'(a), rd_v);
      check("reset_word", rd_v, exp_rst[a]);
    end

    // One-shot compare on a free-running count.
    wb_write(3'd4, 4'hF, 32'h20);
    wb_write(3'd2, 4'h1, 32'h1);
    wb_write(3'd0, 4'h1, 32'h01);
    count = 0; cnt_run = 1;
    repeat (40) tick();
    check("oneshot_irq0", {29'h0, irq}, 32'h1);
    wb_read(3'd0, rd_v);
    check("oneshot_ctrl", rd_v, 32'h0);
    wb_read(3'd3, rd_v);
    check("oneshot_hits", rd_v, 32'h1);
    count = 32'h18;
    repeat (16) tick();
    wb_read(3'd3, rd_v);
    check("oneshot_nohit", rd_v, 32'h1);

    // Periodic channel 1, reloaded counter, W1C and saturation.
    wb_write(3'd5, 4'hF, 32'h10);
    wb_write(3'd2, 4'h1, 32'h3);
    wb_write(3'd0, 4'h1, 32'h22);
    for (int p = 0; p < 300; p++) begin
      count = 32'h0E;
      repeat (4) tick();
      if (p == 0) begin
        wb_read(3'd3, rd_v);
        check("periodic_hit1_first", {24'h0, rd_v[15:8]}, 32'h1);
        wb_write(3'd1, 4'h1, 32'h2);
        check("w1c_irq1", {31'h0, irq[1]}, 32'h0);
      end
    end
    wb_read(3'd3, rd_v);
    check("hit1_saturated", {24'h0, rd_v[15:8]}, 32'hFF);

    // Counter stalled on a match fires exactly once.
    cnt_run = 0;
    wb_write(3'd0, 4'h1, 32'h0);
    wb_write(3'd1, 4'h1, 32'h7);
    wb_write(3'd6, 4'hF, 32'h55);
    count = 32'h55;
    wb_write(3'd0, 4'h1, 32'h04);
    repeat (10) tick();
    wb_read(3'd3, rd_v);
    check("stall_hit2", {24'h0, rd_v[23:16]}, 32'h1);
    wb_read(3'd1, rd_v);
    check("stall_status", rd_v, 32'h4);

    // W1C of pend0 in the same cycle as rise_0: set wins.
    wb_write(3'd0, 4'h1, 32'h0);
    wb_write(3'd1, 4'h1, 32'h7);
    wb_write(3'd4, 4'hF, 32'h40);
    count = 32'h30;
    wb_write(3'd0, 4'h1, 32'h01);
    count = 32'h40;
    valid = 1; we = 1; adr = 3'd1; sel = 4'h1; wdata = 32'h1;
    tick();
    valid = 0; we = 0;
    tick();
    wb_read(3'd1, rd_v);
    check("set_beats_w1c", {31'h0, rd_v[0]}, 32'h1);

    // Byte-lane compare write clears the hit counter.
    wb_write(3'd4, 4'hF, 32'hFFFF_FFFF);
    count = 32'hFFFF_FFFF;
    wb_write(3'd0, 4'h1, 32'h11);
    repeat (3) tick();
    wb_read(3'd3, rd_v);
    check("hit0_before", {24'h0, rd_v[7:0]}, 32'h1);
    wb_write(3'd4, 4'b0010, 32'h0000_AB00);
    wb_read(3'd4, rd_v);
    check("cmp0_bytewrite", rd_v, 32'hFFFF_ABFF);
    wb_read(3'd3, rd_v);
    check("hit0_cleared", {24'h0, rd_v[7:0]}, 32'h0);

    // Reset on top of a request: no ack, everything back to reset values.
    valid = 1; we = 1; adr = 3'd2; sel = 4'h1; wdata = 32'h7; reset = 1;
    tick();
    check("reset_no_ack", {31'h0, ready}, 32'h0);
    reset = 0; valid = 0; we = 0;
    tick();
    check("reset_no_ack_late", {31'h0, ready}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      wb_read(3'(a), rd_v);
      check("post_reset_word", rd_v, exp_rst[a]);
    end

    // Randomized traffic on a small count range so matches are frequent.
    cnt_run = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      valid = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      adr   = 3'($urandom_range(0, 7));
      sel   = 4'($urandom);
      wdata = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 63)) : $urandom;
      r = $urandom_range(0, 3);
      if (r == 1 || r == 2) count = count + 1;
      else if (r == 3) count = 32'($urandom_range(0, 63));
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 0; valid = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
